// File: rtl/mod_dac_pkg.sv
// Shared types and frame-length helper for the serial DAC output stage.
// MOD_DAC_LDAC_EN adds the LDAC strobe state to every frame.
package mod_dac_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StShift,
      StHold,
      StLdac
   } dac_state_e;

   // Cycles from the first cs_n-low cycle to the frame_done pulse.
   function automatic int unsigned frame_len(input int unsigned dac_width,
                                             input int unsigned clk_div);
`ifdef MOD_DAC_LDAC_EN
      return (2 * dac_width + 3) * clk_div;
`else
      return (2 * dac_width + 2) * clk_div;
`endif
   endfunction

endpackage

// File: rtl/mod_dac_rate_gen.sv
// Frame-rate divider: emits a registered one-cycle tick every SAMPLE_DIV cycles while enabled.
module mod_dac_rate_gen #(
   parameter int unsigned SAMPLE_DIV = 200
) (
   input  logic clk_in,
   input  logic RST,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tick_q, tick_d;

   always_comb begin
      cnt_d  = '0;
      tick_d = 1'b0;
      if (enable) begin
         if (cnt_q == CntW'(SAMPLE_DIV - 1)) begin
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/mod_dac_spi.sv
// Serial DAC output stage: resamples wave_in once per frame and shifts it out over mode-0 SPI.
// MOD_DAC_LDAC_EN compiles in an LDAC low pulse after each frame; otherwise dac_ldac_n is tied 1.
module mod_dac_spi
   import mod_dac_pkg::*;
#(
   parameter int unsigned INPUT_WIDTH = 12,
   parameter int unsigned DAC_WIDTH   = 16,
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned SAMPLE_DIV  = 200
) (
   input  logic                   clk_in,
   input  logic                   RST,
   input  logic                   enable,
   input  logic [INPUT_WIDTH-1:0] wave_in,
   output logic                   dac_sclk,
   output logic                   dac_sdo,
   output logic                   dac_cs_n,
   output logic                   dac_ldac_n,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   overrun
);

   localparam int unsigned HcntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BitW  = $clog2(DAC_WIDTH);

   // At this ratio every tick lands inside a running frame and overrun sets each frame.
   if (SAMPLE_DIV <= frame_len(DAC_WIDTH, CLK_DIV)) begin : g_rate_too_fast
   end

   logic                 tick;
   logic [DAC_WIDTH-1:0] word;

   dac_state_e           state_q, state_d;
   logic [HcntW-1:0]     hcnt_q, hcnt_d;
   logic [BitW-1:0]      bit_q, bit_d;
   logic [DAC_WIDTH-1:0] shreg_q, shreg_d;
   logic                 sclk_q, sclk_d;
   logic                 sdo_q, sdo_d;
   logic                 cs_n_q, cs_n_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 overrun_q, overrun_d;
   logic                 hcnt_last;
`ifdef MOD_DAC_LDAC_EN
   logic                 ldac_n_q, ldac_n_d;
`endif

   mod_dac_rate_gen #(
      .SAMPLE_DIV (SAMPLE_DIV)
   ) u_rate_gen (
      .clk_in (clk_in),
      .RST    (RST),
      .enable (enable),
      .tick   (tick)
   );

   if (INPUT_WIDTH == DAC_WIDTH) begin : g_word_eq
      assign word = wave_in;
   end else if (INPUT_WIDTH < DAC_WIDTH) begin : g_word_pad
      assign word = {wave_in, {(DAC_WIDTH - INPUT_WIDTH){1'b0}}};
   end else begin : g_word_trunc
      assign word = wave_in[INPUT_WIDTH-1 -: DAC_WIDTH];
   end

   assign hcnt_last = (hcnt_q == HcntW'(CLK_DIV - 1));

   // Output registers are loaded with the values belonging to the next state.
   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      sclk_d  = 1'b0;
      sdo_d   = 1'b0;
      cs_n_d  = 1'b1;
      done_d  = 1'b0;
`ifdef MOD_DAC_LDAC_EN
      ldac_n_d = 1'b1;
`endif
      case (state_q)
         StIdle: begin
            if (tick) begin
               state_d = StSetup;
               hcnt_d  = '0;
               shreg_d = word;
               cs_n_d  = 1'b0;
               sdo_d   = word[DAC_WIDTH-1];
            end
         end
         StSetup: begin
            cs_n_d = 1'b0;
            sdo_d  = shreg_q[DAC_WIDTH-1];
            if (hcnt_last) begin
               state_d = StShift;
               hcnt_d  = '0;
               bit_d   = '0;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         StShift: begin
            cs_n_d = 1'b0;
            sclk_d = sclk_q;
            sdo_d  = shreg_q[DAC_WIDTH-1];
            if (hcnt_last) begin
               hcnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  // Falling edge: present the next bit.
                  sclk_d  = 1'b0;
                  shreg_d = {shreg_q[DAC_WIDTH-2:0], 1'b0};
                  sdo_d   = shreg_q[DAC_WIDTH-2];
                  if (bit_q == BitW'(DAC_WIDTH - 1)) begin
                     state_d = StHold;
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         StHold: begin
            cs_n_d = 1'b0;
            sdo_d  = shreg_q[DAC_WIDTH-1];
            if (hcnt_last) begin
               hcnt_d = '0;
               cs_n_d = 1'b1;
               sdo_d  = 1'b0;
`ifdef MOD_DAC_LDAC_EN
               state_d  = StLdac;
               ldac_n_d = 1'b0;
`else
               state_d = StIdle;
               done_d  = 1'b1;
`endif
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
`ifdef MOD_DAC_LDAC_EN
         StLdac: begin
            ldac_n_d = 1'b0;
            if (hcnt_last) begin
               hcnt_d   = '0;
               state_d  = StIdle;
               ldac_n_d = 1'b1;
               done_d   = 1'b1;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
`endif
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign busy_d    = (state_d != StIdle);
   // A tick during a frame drops its sample; clearing via enable has priority.
   assign overrun_d = enable & (overrun_q | (tick & (state_q != StIdle)));

   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         state_q   <= StIdle;
         hcnt_q    <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         sclk_q    <= 1'b0;
         sdo_q     <= 1'b0;
         cs_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hcnt_q    <= hcnt_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         sclk_q    <= sclk_d;
         sdo_q     <= sdo_d;
         cs_n_q    <= cs_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

`ifdef MOD_DAC_LDAC_EN
   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         ldac_n_q <= 1'b1;
      end else begin
         ldac_n_q <= ldac_n_d;
      end
   end

   assign dac_ldac_n = ldac_n_q;
`else
   assign dac_ldac_n = 1'b1;
`endif

   assign dac_sclk   = sclk_q;
   assign dac_sdo    = sdo_q;
   assign dac_cs_n   = cs_n_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign overrun    = overrun_q;

endmodule
